// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo - FIFO-buffered UART transmitter streaming back-to-back frames
// Revision 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               TxD,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int c_CW       = $clog2(FIFO_DEPTH+1);
  localparam int c_PW       = $clog2(FIFO_DEPTH);
  localparam int c_STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int c_BW       = $clog2(c_STOP_LEN);
  localparam int c_IW       = $clog2(DATA_BITS);

  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(c_STOP_LEN - 1);
  localparam logic [c_IW-1:0] c_DATA_LAST = c_IW'(DATA_BITS - 1);
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [c_PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [c_CW-1:0]      count_q, count_d;

  state_e               state_q;
  logic [c_BW-1:0]      baud_q;
  logic [c_IW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 txd_q;
  logic                 busy_q;

  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_par;

  assign in_ready   = (count_q != c_FULL);
  assign w_push     = in_valid && in_ready && !reset;
  assign w_head     = mem_q[rd_ptr_q];
  assign w_par      = (PARITY == 2) ? ~^w_head : ^w_head;

  // The FSM takes the next word either from IDLE or on the final stop cycle,
  // which is what gives zero idle gap between queued frames.
  assign w_pop = (count_q != '0) &&
                 ((state_q == S_IDLE) || (state_q == S_STOP && baud_q == c_STOP_LAST));

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            shift_q <= w_head;
            par_q   <= w_par;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            baud_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == c_BIT_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == c_BIT_LAST) begin
            baud_q <= '0;
            if (bit_q == c_DATA_LAST) begin
              if (PARITY != 0) begin
                txd_q   <= par_q;
                state_q <= S_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_q == c_BIT_LAST) begin
            baud_q  <= '0;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_q == c_STOP_LAST) begin
            baud_q <= '0;
            if (w_pop) begin
              shift_q <= w_head;
              par_q   <= w_par;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          baud_q  <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TxD        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo - scoreboard bench over four parity/stop-bit configurations
// Revision 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int C = 4;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data    [N];
  logic       in_valid   [N];
  logic       in_ready   [N];
  logic       txd        [N];
  logic       busy       [N];
  logic [2:0] fifo_count [N];

  int         n_vec = 0;
  int         n_err = 0;
  bit         saw_full;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // Instance 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits.
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (8),
      .PARITY      ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS   ((g == 3) ? 2 : 1),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .TxD       (txd[g]),
      .busy      (busy[g]),
      .fifo_count(fifo_count[g])
    );
  end

  function automatic int par_of(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    int t = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && t < 400) begin
      chk("full_count", fifo_count[k], 4);
      saw_full = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("push_ready", in_ready[k], 1);
    if (in_ready[k]) exp_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic rx_frame(input int k, output int waited);
    logic [15:0] bits;
    logic [7:0]  d;
    logic [7:0]  got;
    int          nb;
    int          pb;
    waited = 0;
    @(negedge clk);
    while (txd[k] !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (txd[k] !== 1'b0) begin
      chk("start_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    d         = exp_q.pop_front();
    pb        = (par_of(k) != 0) ? 1 : 0;
    nb        = 1 + 8 + pb + stop_of(k);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pb != 0) bits[9] = (par_of(k) == 1) ? ^d : ~^d;
    got = '0;
    for (int i = 0; i < nb * C; i++) begin
      if (i > 0) @(negedge clk);
      chk("txd", txd[k], bits[i / C]);
      chk("busy", busy[k], 1);
      if (i / C >= 1 && i / C <= 8 && i % C == C / 2) got[i / C - 1] = txd[k];
    end
    chk("rx_data", got, d);
  endtask

  task automatic idle_chk(input int k);
    @(negedge clk);
    chk("idle_busy", busy[k], 0);
    chk("idle_txd", txd[k], 1);
    chk("idle_count", fifo_count[k], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int t;
    int lows;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = '0;
    end
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hAA;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_txd", txd[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_count", fifo_count[k], 0);
      chk("rst_ready", in_ready[k], 1);
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 0x55 with first-word latency
    push(0, 8'h55);
    chk("lat_count", fifo_count[0], 1);
    chk("lat_txd", txd[0], 1);
    chk("lat_busy", busy[0], 0);
    rx_frame(0, w);
    chk("lat_start", w, 1);
    idle_chk(0);

    // even and odd parity on 0x07
    push(1, 8'h07);
    rx_frame(1, w);
    idle_chk(1);
    push(2, 8'h07);
    rx_frame(2, w);
    idle_chk(2);

    // two stop bits, back-to-back frames
    push(3, 8'hA3);
    push(3, 8'h3C);
    rx_frame(3, w);
    rx_frame(3, w);
    chk("b2b_gap", w, 0);
    idle_chk(3);

    // six words held valid while busy; FIFO must fill and drain in order
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, 8'(8'h31 + i * 8'h17));
      end
      begin
        int wa;
        for (int i = 0; i < 6; i++) rx_frame(0, wa);
      end
    join
    chk("saw_full", saw_full, 1);
    idle_chk(0);

    // push on the same edge the FSM pops, with two words queued
    fork
      begin
        int wb;
        for (int i = 0; i < 4; i++) rx_frame(0, wb);
      end
      begin
        push(0, 8'hC1);
        push(0, 8'h5A);
        push(0, 8'h3E);
        repeat (38) @(posedge clk);
        #1;
        chk("pp_count_before", fifo_count[0], 2);
        chk("pp_ready_before", in_ready[0], 1);
        in_data[0]  = 8'h77;
        in_valid[0] = 1'b1;
        exp_q.push_back(8'h77);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk("pp_count_after", fifo_count[0], 2);
        chk("pp_ready_after", in_ready[0], 1);
      end
    join
    idle_chk(0);

    // reset at cycle 13 of a frame with another word queued
    push(0, 8'hF0);
    push(0, 8'h11);
    t = 0;
    @(negedge clk);
    while (txd[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_start", txd[0], 0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", txd[0], 1);
    chk("mid_rst_count", fifo_count[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_ready", in_ready[0], 1);
    rst = 1'b0;
    exp_q.delete();
    push(0, 8'h96);
    rx_frame(0, w);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    chk("flushed_lows", lows, 0);
    chk("flushed_busy", busy[0], 0);

    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
